// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package rv_wb_pkg;

    localparam int unsigned NUM_MASTERS        = 2;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_ERR  = 2'd3
    } arb_state_e;

    typedef logic [0:0] mst_idx_t;

    localparam mst_idx_t MST_M0 = 1'b0;
    localparam mst_idx_t MST_M1 = 1'b1;

    // One-hot vector selecting the given master.
    function automatic logic [NUM_MASTERS-1:0] mst_onehot(input mst_idx_t idx);
        logic [NUM_MASTERS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rv_wb_timeout.sv
// Saturating slave-ack wait counter; flags when the wait limit has been reached.
module rv_wb_timeout
    import rv_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_limit
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority, increment stops at the limit so it never wraps.
    always_comb begin
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_at_limit = (cnt_q == LIMIT);

endmodule

// File: rtl/rv_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with burst locking and ack timeout.
module rv_wb_arbiter
    import rv_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [1:0]  i_m_cyc,
    input  logic [1:0]  i_m_stb,
    input  logic [1:0]  i_m_we,
    input  logic [7:0]  i_m_sel,
    input  logic [63:0] i_m_adr,
    input  logic [63:0] i_m_dat,
    output logic [31:0] o_m_dat,
    output logic [1:0]  o_m_ack,
    output logic [1:0]  o_m_err,
    output logic        o_s_cyc,
    output logic        o_s_stb,
    output logic        o_s_we,
    output logic [3:0]  o_s_sel,
    output logic [31:0] o_s_adr,
    output logic [31:0] o_s_dat,
    input  logic [31:0] i_s_dat,
    input  logic        i_s_ack,
    output logic [1:0]  o_grant
);

    arb_state_e state_q, state_d;
    mst_idx_t   last_q, last_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] err_q, err_d;

    logic       own_s;
    mst_idx_t   own_idx_s;
    logic       own_cyc_s;
    logic       own_stb_s;
    mst_idx_t   win_s;
    logic       at_limit_s;
    logic       fire_s;

    // Decode whether a master currently owns the bus, and which one.
    always_comb begin
        own_s     = 1'b0;
        own_idx_s = MST_M0;
        case (state_q)
            ST_OWN0: begin
                own_s     = 1'b1;
                own_idx_s = MST_M0;
            end
            ST_OWN1: begin
                own_s     = 1'b1;
                own_idx_s = MST_M1;
            end
            default: begin
                own_s     = 1'b0;
                own_idx_s = MST_M0;
            end
        endcase
    end

    assign own_cyc_s = i_m_cyc[own_idx_s];
    assign own_stb_s = i_m_stb[own_idx_s];

    // Round-robin pick: on contention the master not granted last time wins.
    always_comb begin
        if (i_m_cyc == 2'b11) begin
            win_s = ~last_q;
        end else if (i_m_cyc[1]) begin
            win_s = MST_M1;
        end else begin
            win_s = MST_M0;
        end
    end

    rv_wb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clr     (~own_s | i_s_ack | ~own_stb_s),
        .i_inc     (own_s & own_stb_s & ~i_s_ack),
        .o_at_limit(at_limit_s)
    );

    // An ack in the limit cycle wins over the timeout.
    assign fire_s = own_s & own_stb_s & ~i_s_ack & at_limit_s;

    // Next-state, grant and error computation.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        err_d   = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (i_m_cyc != 2'b00) begin
                    state_d = (win_s == MST_M1) ? ST_OWN1 : ST_OWN0;
                    last_d  = win_s;
                    grant_d = mst_onehot(win_s);
                end else begin
                    grant_d = 2'b00;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!own_cyc_s) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                end else if (fire_s) begin
                    state_d = ST_ERR;
                    grant_d = 2'b00;
                    err_d   = mst_onehot(own_idx_s);
                end else begin
                    state_d = state_q;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // Arbitration FSM with registered grant and error outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            last_q  <= MST_M1;
            grant_q <= 2'b00;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            err_q   <= err_d;
        end
    end

    // Slave-side mux and ack routing; everything quiet when nobody owns the bus.
    always_comb begin
        if (own_s) begin
            o_s_cyc = own_cyc_s;
            o_s_stb = own_stb_s;
            o_s_we  = i_m_we[own_idx_s];
            o_s_sel = (own_idx_s == MST_M1) ? i_m_sel[7:4]   : i_m_sel[3:0];
            o_s_adr = (own_idx_s == MST_M1) ? i_m_adr[63:32] : i_m_adr[31:0];
            o_s_dat = (own_idx_s == MST_M1) ? i_m_dat[63:32] : i_m_dat[31:0];
            o_m_ack = (own_idx_s == MST_M1) ? {i_s_ack, 1'b0} : {1'b0, i_s_ack};
        end else begin
            o_s_cyc = 1'b0;
            o_s_stb = 1'b0;
            o_s_we  = 1'b0;
            o_s_sel = 4'h0;
            o_s_adr = 32'h0000_0000;
            o_s_dat = 32'h0000_0000;
            o_m_ack = 2'b00;
        end
    end

    assign o_m_dat = i_s_dat;
    assign o_grant = grant_q;
    assign o_m_err = err_q;

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Directed, table-driven bench for rv_wb_arbiter (TIMEOUT_CYCLES = 4).
module tb_rv_wb_arbiter;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [7:0]  m_sel;
    logic [63:0] m_adr, m_dat;
    logic [31:0] s_dat_in;
    logic        s_ack;
    logic [31:0] o_m_dat;
    logic [1:0]  o_m_ack, o_m_err, o_grant;
    logic        o_s_cyc, o_s_stb, o_s_we;
    logic [3:0]  o_s_sel;
    logic [31:0] o_s_adr, o_s_dat;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv_wb_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we), .i_m_sel(m_sel),
        .i_m_adr(m_adr), .i_m_dat(m_dat), .o_m_dat(o_m_dat),
        .o_m_ack(o_m_ack), .o_m_err(o_m_err),
        .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
        .o_s_sel(o_s_sel), .o_s_adr(o_s_adr), .o_s_dat(o_s_dat),
        .i_s_dat(s_dat_in), .i_s_ack(s_ack), .o_grant(o_grant)
    );

    typedef struct {
        string      nm;
        logic [1:0] cyc;
        logic [1:0] stb;
        logic       ack;
        logic [1:0] e_grant;
        logic [1:0] e_ack;
        logic [1:0] e_err;
        logic [1:0] e_bus;   // 00 none, 01 M0 fields on slave bus, 10 M1 fields
        logic       e_scyc;
        logic       e_sstb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic [1:0] cyc, logic [1:0] stb, logic ack,
                                logic [1:0] eg, logic [1:0] ea, logic [1:0] ee,
                                logic [1:0] eb, logic esc, logic ess);
        vec_t v;
        v.nm = nm; v.cyc = cyc; v.stb = stb; v.ack = ack;
        v.e_grant = eg; v.e_ack = ea; v.e_err = ee; v.e_bus = eb;
        v.e_scyc = esc; v.e_sstb = ess;
        return v;
    endfunction

    task automatic check(input string nm, input logic [1:0] eg, input logic [1:0] ea,
                         input logic [1:0] ee, input logic [1:0] eb, input logic esc,
                         input logic ess, input logic [31:0] emd);
        logic [3:0]  esel;
        logic [31:0] eadr;
        logic [31:0] edat;
        logic        ewe;
        case (eb)
            2'b01:   begin esel = 4'hF; eadr = 32'h0000_1000; edat = 32'hD0D0_0000; ewe = 1'b1; end
            2'b10:   begin esel = 4'h3; eadr = 32'h0000_2000; edat = 32'hD1D1_1111; ewe = 1'b0; end
            default: begin esel = 4'h0; eadr = 32'h0000_0000; edat = 32'h0000_0000; ewe = 1'b0; end
        endcase
        n_vec++;
        if ({o_grant, o_m_ack, o_m_err, o_s_cyc, o_s_stb, o_s_we, o_s_sel, o_s_adr, o_s_dat, o_m_dat}
            !== {eg, ea, ee, esc, ess, ewe, esel, eadr, edat, emd}) begin
            n_bad++;
            $display("FAIL %s: got grant=%b ack=%b err=%b scyc=%b sstb=%b swe=%b sel=%h adr=%h dat=%h mdat=%h ; want grant=%b ack=%b err=%b scyc=%b sstb=%b swe=%b sel=%h adr=%h dat=%h mdat=%h",
                     nm, o_grant, o_m_ack, o_m_err, o_s_cyc, o_s_stb, o_s_we, o_s_sel, o_s_adr,
                     o_s_dat, o_m_dat, eg, ea, ee, esc, ess, ewe, esel, eadr, edat, emd);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            m_cyc    = vecs[i].cyc;
            m_stb    = vecs[i].stb;
            s_ack    = vecs[i].ack;
            s_dat_in = 32'hC0DE_0000 + 32'(i);
            #1;
            check(vecs[i].nm, vecs[i].e_grant, vecs[i].e_ack, vecs[i].e_err, vecs[i].e_bus,
                  vecs[i].e_scyc, vecs[i].e_sstb, s_dat_in);
        end
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        m_cyc = 2'b00; m_stb = 2'b00; s_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        check(nm, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, s_dat_in);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    int s1_lo, s1_hi, s2_lo, s2_hi;

    initial begin
        rst_n    = 1'b0;
        m_cyc    = 2'b00;
        m_stb    = 2'b00;
        m_we     = 2'b01;
        m_sel    = {4'h3, 4'hF};
        m_adr    = {32'h0000_2000, 32'h0000_1000};
        m_dat    = {32'hD1D1_1111, 32'hD0D0_0000};
        s_dat_in = 32'h0000_0000;
        s_ack    = 1'b0;

        // Single M0 write, slave acks one cycle after the grant.
        s1_lo = vecs.size();
        vecs.push_back(mk("s1_req_idle", 2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk("s1_grant_m0", 2'b01, 2'b01, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1));
        vecs.push_back(mk("s1_ack_m0",   2'b01, 2'b01, 1'b1, 2'b01, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1));
        vecs.push_back(mk("s1_drop_cyc", 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0));
        vecs.push_back(mk("s1_idle",     2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        s1_hi = vecs.size();

        // From a fresh reset: contention, round robin, burst lock, timeout, late acks.
        s2_lo = vecs.size();
        vecs.push_back(mk("rr_req_both1", 2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk("rr_grant_m0",  2'b11, 2'b11, 1'b1, 2'b01, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1));
        vecs.push_back(mk("rr_rel1",      2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0));
        vecs.push_back(mk("rr_req_both2", 2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk("rr_grant_m1",  2'b11, 2'b11, 1'b1, 2'b10, 2'b10, 2'b00, 2'b10, 1'b1, 1'b1));
        vecs.push_back(mk("rr_rel2",      2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0));
        vecs.push_back(mk("rr_idle",      2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));

        vecs.push_back(mk("bu_req_m1", 2'b10, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk($sformatf("bu_beat%0d", k + 1), 2'b11, 2'b11, 1'b1,
                              2'b10, 2'b10, 2'b00, 2'b10, 1'b1, 1'b1));
        vecs.push_back(mk("bu_m1_drop",     2'b01, 2'b01, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0));
        vecs.push_back(mk("bu_idle_m0_req", 2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk("bu_grant_m0",    2'b01, 2'b01, 1'b1, 2'b01, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1));
        vecs.push_back(mk("bu_m0_drop",     2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0));
        vecs.push_back(mk("bu_idle",        2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));

        vecs.push_back(mk("to_req_m1", 2'b10, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk($sformatf("to_wait%0d", k + 1), 2'b10, 2'b10, 1'b0,
                              2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1));
        vecs.push_back(mk("to_err",        2'b10, 2'b10, 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk("to_idle_rereq", 2'b10, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk("to_regrant",    2'b10, 2'b10, 1'b1, 2'b10, 2'b10, 2'b00, 2'b10, 1'b1, 1'b1));
        vecs.push_back(mk("to_drop",       2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0));
        vecs.push_back(mk("to_idle",       2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));

        vecs.push_back(mk("ak_req_m0", 2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk($sformatf("ak_wait%0d", k + 1), 2'b01, 2'b01, 1'b0,
                              2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1));
        vecs.push_back(mk("ak_ack_wait4", 2'b01, 2'b01, 1'b1, 2'b01, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk($sformatf("ak_rewait%0d", k + 1), 2'b01, 2'b01, 1'b0,
                              2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1));
        vecs.push_back(mk("ak_ack_at_limit", 2'b01, 2'b01, 1'b1, 2'b01, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1));
        vecs.push_back(mk("ak_no_err",       2'b01, 2'b01, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1));
        vecs.push_back(mk("ak_drop",         2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0));
        vecs.push_back(mk("ak_idle",         2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        s2_hi = vecs.size();

        // Reset state.
        #2;
        check("reset_state", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, s_dat_in);
        @(negedge clk);
        rst_n = 1'b1;

        run_vecs(s1_lo, s1_hi);
        do_reset("reset_between");
        run_vecs(s2_lo, s2_hi);

        // Reset pulsed while M0 waits on the slave, then M0 is granted again.
        @(negedge clk);
        m_cyc = 2'b01; m_stb = 2'b01; s_ack = 1'b0;
        @(negedge clk);
        #1;
        check("rs_owned", 2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, s_dat_in);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_async_clear", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, s_dat_in);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rs_release_idle", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, s_dat_in);
        @(negedge clk);
        #1;
        check("rs_regrant_m0", 2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, s_dat_in);
        s_ack = 1'b1;
        #1;
        check("rs_ack_m0", 2'b01, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1, s_dat_in);
        @(negedge clk);
        m_cyc = 2'b00; m_stb = 2'b00; s_ack = 1'b0;
        @(negedge clk);
        #1;
        check("rs_final_idle", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, s_dat_in);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rv_wb_arbiter.md
RV_WB_ARBITER -- requirements
Module: rv_wb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: slave ack wait limit in cycles while stb is high; legal range 1..65535.
REQ-002 Port i_clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port i_reset_n  in  1  asynchronous, active-low reset.
REQ-004 Port i_m_cyc  in  2  per-master Wishbone cyc; bit 0 is M0 (core data port), bit 1 is M1 (secondary master).
REQ-005 Port i_m_stb  in  2  per-master strobe.
REQ-006 Port i_m_we  in  2  per-master write enable.
REQ-007 Port i_m_sel  in  8  per-master byte select; [3:0] is M0, [7:4] is M1.
REQ-008 Port i_m_adr  in  64  per-master address; [31:0] is M0, [63:32] is M1.
REQ-009 Port i_m_dat  in  64  per-master write data, packed as i_m_adr.
REQ-010 Port o_m_dat  out  32  read data, broadcast to both masters.
REQ-011 Port o_m_ack  out  2  per-master ack.
REQ-012 Port o_m_err  out  2  per-master error (timeout).
REQ-013 Port o_s_cyc, o_s_stb, o_s_we  out  1 each  slave control.
REQ-014 Port o_s_sel  out  4 / o_s_adr  out  32 / o_s_dat  out  32  slave select, address, write data.
REQ-015 Port i_s_dat  in  32 / i_s_ack  in  1  slave read data, ack.
REQ-016 Port o_grant  out  2  one-hot current owner; 00 when idle.

Function
REQ-017 FSM states: IDLE, OWN0, OWN1, ERR.
- IDLE->OWNx on a request; no slave access in the request cycle.
- OWNx->IDLE on the first cycle with i_m_cyc[x]=0.
- OWNx->ERR on timeout.
- ERR->IDLE unconditionally after exactly one cycle.
REQ-018 Grant latency: a request arriving in IDLE is granted on the next edge; o_grant is registered.
REQ-019 Simultaneous requests in IDLE: the master not granted most recently wins (round-robin); the loser waits and is not acked.
REQ-020 Ownership is locked for the owner's whole cyc burst; the other master's requests are ignored until the FSM returns to IDLE.
REQ-021 In OWNx:
- o_s_cyc/stb/we/sel/adr/dat are combinationally muxed from master x.
- o_m_ack[x] = i_s_ack.
- The other master's ack and err are 0.
REQ-022 In IDLE and ERR:
- o_s_cyc = o_s_stb = o_s_we = 0.
- o_s_sel, o_s_adr, o_s_dat are 0.
- o_m_ack = 00.
REQ-023 o_m_dat = i_s_dat in all states; masters qualify it with their own ack.
REQ-024 Timeout counter:
- Width is ceil(log2(TIMEOUT_CYCLES+1)).
- Clears on i_s_ack, when stb is low, and on entry to OWNx.
- Increments on each owner-stb-high cycle without ack.
- Saturates and never wraps.
REQ-025 Timeout fires when the counter equals TIMEOUT_CYCLES with stb high and no ack.
- FSM goes to ERR.
- o_m_err[x] is 1 for exactly the ERR cycle.
- o_s_cyc drops in that same ERR cycle.
REQ-026 Ack and timeout in the same cycle: ack wins, err stays 0, counter clears.
REQ-027 Owner drops cyc in the same cycle the slave acks: the ack is passed through, then the FSM returns to IDLE.
REQ-028 Back-to-back use by one master with cyc held high is permitted indefinitely.
REQ-029 A master that keeps cyc high after err is treated as a new request from IDLE.

Reset
REQ-030 On i_reset_n low, immediately (asynchronously):
- FSM = IDLE, counter = 0, last-grant = M1 (so M0 wins first contention).
- o_grant = 00, o_m_ack = 00, o_m_err = 00, all slave controls 0.
REQ-031 Reset asserted mid-transfer aborts the transfer without ack or err; after deassertion, arbitration restarts from the IDLE state.

Structure
REQ-032 Shared package rv_wb_pkg holds the FSM state enum, master-index type, master count (2) and the TIMEOUT_CYCLES default.
REQ-033 One sub-module, rv_wb_timeout, implements the saturating counter and timeout flag; the arbiter instantiates it once.

Verification
REQ-034 The bench covers these directed scenarios:
- Reset, then M0 cyc/stb write to 0x0000_1000, sel=0xF, slave acks 1 cycle later -> o_grant=01 one cycle after request; o_s_adr=0x0000_1000; o_m_ack=01 for 1 cycle; no M1 ack.
- M0 and M1 request together from IDLE, twice, releasing between -> first grant M0, second grant M1.
- M1 owns a 4-beat cyc burst while M0 requests -> M0 ungranted until M1 drops cyc; M0 granted on the next edge.
- TIMEOUT_CYCLES=4, slave never acks M1 -> o_m_err=10 for 1 cycle, o_s_cyc=0, FSM back to IDLE.
- TIMEOUT_CYCLES=4, ack arrives on the 4th wait cycle -> o_m_ack asserted, o_m_err stays 0.
- i_reset_n pulsed low mid-wait -> all outputs 0 at once; a post-reset M0 request is granted normally.
